// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS control/execute core: FSM states,
// opcode/funct encodings, the control-strobe bundle and immediate helpers.
package mips_pkg;

    typedef logic [31:0] size_t;
    typedef logic [4:0]  regaddr_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL   = 6'h00,
        FN_SRL   = 6'h02,
        FN_SRA   = 6'h03,
        FN_SLLV  = 6'h04,
        FN_SRLV  = 6'h06,
        FN_SRAV  = 6'h07,
        FN_JR    = 6'h08,
        FN_MFHI  = 6'h10,
        FN_MTHI  = 6'h11,
        FN_MFLO  = 6'h12,
        FN_MTLO  = 6'h13,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_DIV   = 6'h1A,
        FN_DIVU  = 6'h1B,
        FN_ADDU  = 6'h21,
        FN_SUBU  = 6'h23,
        FN_AND   = 6'h24,
        FN_OR    = 6'h25,
        FN_XOR   = 6'h26,
        FN_NOR   = 6'h27,
        FN_SLT   = 6'h2A,
        FN_SLTU  = 6'h2B
    } func_t;

    typedef struct packed {
        logic pc_wen;
        logic ir_wen;
        logic ram_wen;
        logic ram_rds;
        logic reg_wen;
        logic src_b_sel;
        logic ram_a_sel;
        logic reg_wd_sel;
        logic reg_a3_sel;
        logic pc_src;
    } ctrl_t;

    function automatic size_t sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic size_t zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/mips_divider.sv
// Iterative restoring divider, one quotient bit per cycle (DIV_CYCLES equals
// the 32-bit operand width). The first iteration happens on the start edge.
module mips_divider
    import mips_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  logic  is_signed,
    input  size_t dividend,
    input  size_t divisor,
    output logic  busy,
    output logic  done,
    output size_t quotient,
    output size_t remainder
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic          busy_r, done_r, neg_q_r, neg_r_r, div0_r;
    logic [CW-1:0] cnt_r;
    size_t         rem_r, quo_r, dvs_r;
    logic          dvd_neg_s, dvs_neg_s, ge_s;
    size_t         abs_dvd_s, abs_dvs_s, src_rem_s, src_quo_s, src_dvs_s;
    size_t         diff_s, rem_nxt_s, quo_nxt_s;
    logic [32:0]   rem_sh_s;

    assign dvd_neg_s = is_signed & dividend[31];
    assign dvs_neg_s = is_signed & divisor[31];
    assign abs_dvd_s = dvd_neg_s ? (32'd0 - dividend) : dividend;
    assign abs_dvs_s = dvs_neg_s ? (32'd0 - divisor) : divisor;

    assign src_rem_s = start ? 32'd0 : rem_r;
    assign src_quo_s = start ? abs_dvd_s : quo_r;
    assign src_dvs_s = start ? abs_dvs_s : dvs_r;

    assign rem_sh_s  = {src_rem_s, src_quo_s[31]};
    assign ge_s      = rem_sh_s >= {1'b0, src_dvs_s};
    assign diff_s    = rem_sh_s[31:0] - src_dvs_s;
    assign rem_nxt_s = ge_s ? diff_s : rem_sh_s[31:0];
    assign quo_nxt_s = {src_quo_s[30:0], ge_s};

    // Iteration state: load-and-first-step on start, then one step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= '0;
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            dvs_r   <= 32'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            div0_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                rem_r   <= rem_nxt_s;
                quo_r   <= quo_nxt_s;
                dvs_r   <= abs_dvs_s;
                neg_q_r <= dvd_neg_s ^ dvs_neg_s;
                neg_r_r <= dvd_neg_s;
                div0_r  <= (divisor == 32'd0);
                cnt_r   <= CW'(DIV_CYCLES - 1);
                if (DIV_CYCLES == 1) begin
                    done_r <= 1'b1;
                end else begin
                    busy_r <= 1'b1;
                end
            end else if (busy_r) begin
                rem_r <= rem_nxt_s;
                quo_r <= quo_nxt_s;
                cnt_r <= cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    // Divide by zero overrides the quotient; the remainder already equals the dividend.
    assign quotient  = div0_r ? 32'hFFFF_FFFF : (neg_q_r ? (32'd0 - quo_r) : quo_r);
    assign remainder = neg_r_r ? (32'd0 - rem_r) : rem_r;

endmodule

// File: rtl/mips_ctrl_exec.sv
// Multicycle MIPS control/execute core: instruction-cycle FSM, control decode,
// ALU, and (when MULDIV_EN is defined) HI/LO with an iterative divider.
module mips_ctrl_exec
    import mips_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        halt_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [15:0] immediate_i,
    output logic [1:0]  state_o,
    output logic        active_o,
    output logic        pc_wen_o,
    output logic        ir_wen_o,
    output logic        ram_wen_o,
    output logic        ram_rds_o,
    output logic        reg_wen_o,
    output logic        src_b_sel_o,
    output logic        ram_a_sel_o,
    output logic        reg_wd_sel_o,
    output logic        reg_a3_sel_o,
    output logic        pc_src_o,
    output logic [31:0] rd_o,
    output logic [31:0] rt_o,
    output logic [31:0] mfhi_o,
    output logic [31:0] mflo_o,
    output logic        stall_o
);

    state_t   state_r, state_nxt_s;
    ctrl_t    ctrl_s, ctrl_g_s;
    size_t    rd_s, rt_s, imm_sext_s, imm_zext_s;
    regaddr_t shamt_s;
    logic     r_alu_s, i_alu_s, is_div_s, stall_s;

    assign imm_sext_s = sext16(immediate_i);
    assign imm_zext_s = zext16(immediate_i);
    assign shamt_s    = immediate_i[10:6];

`ifdef MULDIV_EN
    size_t       hi_r, lo_r, div_q_s, div_r_s;
    logic        div_busy_s, div_done_s;
    logic [63:0] prod_s_s, prod_u_s;

    assign is_div_s = (opcode_i == OP_RTYPE) && ((funct_i == FN_DIV) || (funct_i == FN_DIVU));
    assign stall_s  = (state_r == EXEC1) && is_div_s && !div_done_s;
    assign prod_s_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign prod_u_s = {32'd0, rs_i} * {32'd0, rt_i};

    mips_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst_n     (reset_i),
        .start     (stall_s && !div_busy_s),
        .is_signed (funct_i == FN_DIV),
        .dividend  (rs_i),
        .divisor   (rt_i),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (div_q_s),
        .remainder (div_r_s)
    );

    // HI/LO commit on the EXEC1 edge; division results land on its non-stall cycle.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if ((state_r == EXEC1) && (opcode_i == OP_RTYPE)) begin
            case (funct_i)
                FN_MULT:  {hi_r, lo_r} <= prod_s_s;
                FN_MULTU: {hi_r, lo_r} <= prod_u_s;
                FN_MTHI:  hi_r <= rs_i;
                FN_MTLO:  lo_r <= rs_i;
                FN_DIV, FN_DIVU: begin
                    if (div_done_s) begin
                        lo_r <= div_q_s;
                        hi_r <= div_r_s;
                    end
                end
                default: hi_r <= hi_r;
            endcase
        end
    end

    assign mfhi_o = hi_r;
    assign mflo_o = lo_r;
`else
    assign is_div_s = 1'b0;
    assign stall_s  = 1'b0;
    assign mfhi_o   = 32'd0;
    assign mflo_o   = 32'd0;
`endif

    // ALU results and R/I-type register-writing classification.
    always_comb begin
        rd_s    = 32'd0;
        rt_s    = 32'd0;
        r_alu_s = 1'b0;
        i_alu_s = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                r_alu_s = 1'b1;
                case (funct_i)
                    FN_ADDU: rd_s = rs_i + rt_i;
                    FN_SUBU: rd_s = rs_i - rt_i;
                    FN_AND:  rd_s = rs_i & rt_i;
                    FN_OR:   rd_s = rs_i | rt_i;
                    FN_XOR:  rd_s = rs_i ^ rt_i;
                    FN_NOR:  rd_s = ~(rs_i | rt_i);
                    FN_SLT:  rd_s = {31'd0, ($signed(rs_i) < $signed(rt_i))};
                    FN_SLTU: rd_s = {31'd0, (rs_i < rt_i)};
                    FN_SLL:  rd_s = rt_i << shamt_s;
                    FN_SRL:  rd_s = rt_i >> shamt_s;
                    FN_SRA:  rd_s = $signed(rt_i) >>> shamt_s;
                    FN_SLLV: rd_s = rt_i << rs_i[4:0];
                    FN_SRLV: rd_s = rt_i >> rs_i[4:0];
                    FN_SRAV: rd_s = $signed(rt_i) >>> rs_i[4:0];
`ifdef MULDIV_EN
                    FN_MFHI: rd_s = hi_r;
                    FN_MFLO: rd_s = lo_r;
`endif
                    default: r_alu_s = 1'b0;
                endcase
            end
            OP_ADDIU: begin i_alu_s = 1'b1; rt_s = rs_i + imm_sext_s; end
            OP_SLTI:  begin i_alu_s = 1'b1; rt_s = {31'd0, ($signed(rs_i) < $signed(imm_sext_s))}; end
            OP_SLTIU: begin i_alu_s = 1'b1; rt_s = {31'd0, (rs_i < imm_sext_s)}; end
            OP_ANDI:  begin i_alu_s = 1'b1; rt_s = rs_i & imm_zext_s; end
            OP_ORI:   begin i_alu_s = 1'b1; rt_s = rs_i | imm_zext_s; end
            OP_XORI:  begin i_alu_s = 1'b1; rt_s = rs_i ^ imm_zext_s; end
            OP_LUI:   begin i_alu_s = 1'b1; rt_s = {immediate_i, 16'h0000}; end
            OP_LW, OP_SW: rt_s = rs_i + imm_sext_s;
            default:  rt_s = 32'd0;
        endcase
    end

    // Datapath strobes and selects from state and instruction class.
    always_comb begin
        ctrl_s = '0;
        case (state_r)
            FETCH: begin
                ctrl_s.ir_wen  = 1'b1;
                ctrl_s.ram_rds = 1'b1;
            end
            EXEC1: begin
                if (r_alu_s) begin
                    ctrl_s.reg_wen    = 1'b1;
                    ctrl_s.reg_a3_sel = 1'b1;
                    ctrl_s.reg_wd_sel = 1'b1;
                    ctrl_s.pc_wen     = 1'b1;
                end else if (i_alu_s) begin
                    ctrl_s.reg_wen    = 1'b1;
                    ctrl_s.reg_wd_sel = 1'b1;
                    ctrl_s.src_b_sel  = 1'b1;
                    ctrl_s.pc_wen     = 1'b1;
                end else if (opcode_i == OP_LW) begin
                    ctrl_s.ram_rds   = 1'b1;
                    ctrl_s.ram_a_sel = 1'b1;
                    ctrl_s.src_b_sel = 1'b1;
                end else if (opcode_i == OP_SW) begin
                    ctrl_s.ram_wen   = 1'b1;
                    ctrl_s.ram_a_sel = 1'b1;
                    ctrl_s.src_b_sel = 1'b1;
                    ctrl_s.pc_wen    = 1'b1;
                end else if ((opcode_i == OP_RTYPE) && (funct_i == FN_JR)) begin
                    ctrl_s.pc_wen = 1'b1;
                    ctrl_s.pc_src = 1'b1;
                end else if (is_div_s) begin
                    ctrl_s.pc_wen = !stall_s;
                end else begin
                    ctrl_s.pc_wen = 1'b1;
                end
            end
            EXEC2: begin
                if (opcode_i == OP_LW) begin
                    ctrl_s.reg_wen = 1'b1;
                    ctrl_s.pc_wen  = 1'b1;
                end else begin
                    ctrl_s = '0;
                end
            end
            HALT:    ctrl_s = '0;
            default: ctrl_s = '0;
        endcase
    end

    // Instruction-cycle next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FETCH: state_nxt_s = halt_i ? HALT : EXEC1;
            EXEC1: begin
                if (stall_s) begin
                    state_nxt_s = EXEC1;
                end else if (opcode_i == OP_LW) begin
                    state_nxt_s = EXEC2;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            EXEC2:   state_nxt_s = FETCH;
            HALT:    state_nxt_s = HALT;
            default: state_nxt_s = FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign ctrl_g_s     = reset_i ? ctrl_s : '0;
    assign pc_wen_o     = ctrl_g_s.pc_wen;
    assign ir_wen_o     = ctrl_g_s.ir_wen;
    assign ram_wen_o    = ctrl_g_s.ram_wen;
    assign ram_rds_o    = ctrl_g_s.ram_rds;
    assign reg_wen_o    = ctrl_g_s.reg_wen;
    assign src_b_sel_o  = ctrl_g_s.src_b_sel;
    assign ram_a_sel_o  = ctrl_g_s.ram_a_sel;
    assign reg_wd_sel_o = ctrl_g_s.reg_wd_sel;
    assign reg_a3_sel_o = ctrl_g_s.reg_a3_sel;
    assign pc_src_o     = ctrl_g_s.pc_src;
    assign state_o      = state_r;
    assign active_o     = (state_r != HALT);
    assign rd_o         = rd_s;
    assign rt_o         = rt_s;
    assign stall_o      = stall_s;

endmodule

// File: tb/tb_mips_ctrl_exec.sv
// Scoreboard bench for mips_ctrl_exec: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them. Works with or without MULDIV_EN.
module tb_mips_ctrl_exec;

`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam int S_STATE = 0,  S_ACT = 1,  S_PCW = 2,  S_IRW = 3,  S_RAMW = 4,  S_RDS = 5;
    localparam int S_REGW  = 6,  S_SRCB = 7, S_RAS = 8,  S_WD = 9,   S_A3 = 10,   S_PCSRC = 11;
    localparam int S_RD    = 12, S_RT = 13,  S_HI = 14,  S_LO = 15,  S_STALL = 16;

    logic        clk = 1'b0;
    logic        reset_i, halt_i;
    logic [5:0]  opcode_i, funct_i;
    logic [31:0] rs_i, rt_i;
    logic [15:0] immediate_i;
    logic [1:0]  state_o;
    logic        active_o, pc_wen_o, ir_wen_o, ram_wen_o, ram_rds_o, reg_wen_o;
    logic        src_b_sel_o, ram_a_sel_o, reg_wd_sel_o, reg_a3_sel_o, pc_src_o, stall_o;
    logic [31:0] rd_o, rt_o, mfhi_o, mflo_o;

    mips_ctrl_exec #(.DIV_CYCLES(32)) dut (
        .clk(clk), .reset_i(reset_i), .halt_i(halt_i), .opcode_i(opcode_i), .funct_i(funct_i),
        .rs_i(rs_i), .rt_i(rt_i), .immediate_i(immediate_i), .state_o(state_o), .active_o(active_o),
        .pc_wen_o(pc_wen_o), .ir_wen_o(ir_wen_o), .ram_wen_o(ram_wen_o), .ram_rds_o(ram_rds_o),
        .reg_wen_o(reg_wen_o), .src_b_sel_o(src_b_sel_o), .ram_a_sel_o(ram_a_sel_o),
        .reg_wd_sel_o(reg_wd_sel_o), .reg_a3_sel_o(reg_a3_sel_o), .pc_src_o(pc_src_o),
        .rd_o(rd_o), .rt_o(rt_o), .mfhi_o(mfhi_o), .mflo_o(mflo_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int          q_cyc[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];
    int          n_cmp = 0, n_bad = 0;
    bit          end_req = 1'b0;
    logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;
    int          m_c, m_s;
    logic [31:0] m_e, m_a;

    function automatic logic [31:0] act(input int sel);
        case (sel)
            S_STATE: return {30'd0, state_o};
            S_ACT:   return {31'd0, active_o};
            S_PCW:   return {31'd0, pc_wen_o};
            S_IRW:   return {31'd0, ir_wen_o};
            S_RAMW:  return {31'd0, ram_wen_o};
            S_RDS:   return {31'd0, ram_rds_o};
            S_REGW:  return {31'd0, reg_wen_o};
            S_SRCB:  return {31'd0, src_b_sel_o};
            S_RAS:   return {31'd0, ram_a_sel_o};
            S_WD:    return {31'd0, reg_wd_sel_o};
            S_A3:    return {31'd0, reg_a3_sel_o};
            S_PCSRC: return {31'd0, pc_src_o};
            S_RD:    return rd_o;
            S_RT:    return rt_o;
            S_HI:    return mfhi_o;
            S_LO:    return mflo_o;
            S_STALL: return {31'd0, stall_o};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string sname(input int sel);
        case (sel)
            S_STATE: return "state";     S_ACT:   return "active";
            S_PCW:   return "pc_wen";    S_IRW:   return "ir_wen";
            S_RAMW:  return "ram_wen";   S_RDS:   return "ram_rds";
            S_REGW:  return "reg_wen";   S_SRCB:  return "src_b_sel";
            S_RAS:   return "ram_a_sel"; S_WD:    return "reg_wd_sel";
            S_A3:    return "reg_a3_sel"; S_PCSRC: return "pc_src";
            S_RD:    return "rd";        S_RT:    return "rt";
            S_HI:    return "hi";        S_LO:    return "lo";
            S_STALL: return "stall";     default: return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc_cnt) begin
            m_c = q_cyc.pop_front();
            m_s = q_sel.pop_front();
            m_e = q_exp.pop_front();
            m_a = act(m_s);
            n_cmp++;
            if (m_c != cyc_cnt) begin
                n_bad++;
                $display("FAIL %s: due cycle %0d sampled late at %0d, required %h", sname(m_s), m_c, cyc_cnt, m_e);
            end else if (m_a !== m_e) begin
                n_bad++;
                $display("FAIL %s: cycle %0d got %h required %h", sname(m_s), cyc_cnt, m_a, m_e);
            end
        end
        if (end_req) begin
            while (q_cyc.size() > 0) begin
                m_c = q_cyc.pop_front();
                m_s = q_sel.pop_front();
                m_e = q_exp.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: cycle %0d never sampled, required %h", sname(m_s), m_c, m_e);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] v);
        q_cyc.push_back(cyc_cnt);
        q_sel.push_back(sel);
        q_exp.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm, input logic halt);
        opcode_i = op; funct_i = fn; rs_i = rs; rt_i = rt; immediate_i = imm; halt_i = halt;
        chk(S_STATE, 32'd0); chk(S_IRW, 32'd1); chk(S_RDS, 32'd1); chk(S_RAS, 32'd0);
        chk(S_REGW, 32'd0); chk(S_HI, exp_hi); chk(S_LO, exp_lo);
        step();
    endtask

    task automatic exec_r(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] imm, input logic [31:0] exp_rd);
        fetch(6'h00, fn, rs, rt, imm, 1'b0);
        chk(S_STATE, 32'd1); chk(S_RD, exp_rd); chk(S_RT, 32'd0); chk(S_REGW, 32'd1);
        chk(S_A3, 32'd1); chk(S_WD, 32'd1); chk(S_SRCB, 32'd0); chk(S_PCW, 32'd1);
        step();
    endtask

    task automatic exec_i(input logic [5:0] op, input logic [31:0] rs, input logic [15:0] imm,
                          input logic [31:0] exp_rt);
        fetch(op, 6'h00, rs, 32'h5A5A_5A5A, imm, 1'b0);
        chk(S_STATE, 32'd1); chk(S_RT, exp_rt); chk(S_RD, 32'd0); chk(S_REGW, 32'd1);
        chk(S_A3, 32'd0); chk(S_WD, 32'd1); chk(S_SRCB, 32'd1); chk(S_PCW, 32'd1);
        step();
    endtask

    task automatic div_seq(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
        int n;
        n = MD ? 32 : 0;
        fetch(6'h00, fn, rs, rt, 16'h0000, 1'b0);
        for (int k = 0; k <= n; k++) begin
            chk(S_STATE, 32'd1);
            chk(S_STALL, {31'd0, (k < n)});
            chk(S_PCW, {31'd0, (k == n)});
            chk(S_REGW, 32'd0);
            step();
        end
    endtask

    initial begin
        reset_i = 1'b0; halt_i = 1'b0; opcode_i = 6'h00; funct_i = 6'h00;
        rs_i = 32'd0; rt_i = 32'd0; immediate_i = 16'h0000;
        step();
        chk(S_STATE, 32'd0); chk(S_ACT, 32'd1); chk(S_IRW, 32'd0); chk(S_RDS, 32'd0);
        chk(S_PCW, 32'd0); chk(S_PCSRC, 32'd0); chk(S_HI, 32'd0); chk(S_LO, 32'd0); chk(S_STALL, 32'd0);
        step();
        reset_i = 1'b1;

        exec_r(6'h21, 32'd5, 32'd7, 16'h0000, 32'd12);                       // ADDU

        fetch(6'h23, 6'h00, 32'h0000_1000, 32'd0, 16'hFFFC, 1'b0);           // LW
        chk(S_STATE, 32'd1); chk(S_RT, 32'h0000_0FFC); chk(S_RDS, 32'd1); chk(S_RAS, 32'd1);
        chk(S_SRCB, 32'd1); chk(S_REGW, 32'd0); chk(S_PCW, 32'd0);
        step();
        chk(S_STATE, 32'd2); chk(S_REGW, 32'd1); chk(S_WD, 32'd0); chk(S_A3, 32'd0);
        chk(S_PCW, 32'd1); chk(S_RDS, 32'd0);
        step();

        fetch(6'h2B, 6'h00, 32'h0000_0020, 32'h99, 16'h0004, 1'b0);          // SW
        chk(S_STATE, 32'd1); chk(S_RT, 32'h0000_0024); chk(S_RAMW, 32'd1); chk(S_RAS, 32'd1);
        chk(S_SRCB, 32'd1); chk(S_PCW, 32'd1); chk(S_REGW, 32'd0);
        step();

        exec_i(6'h0A, 32'hFFFF_FFFF, 16'h0001, 32'd1);                       // SLTI
        exec_i(6'h0B, 32'hFFFF_FFFF, 16'h0001, 32'd0);                       // SLTIU
        exec_i(6'h0F, 32'd0, 16'hABCD, 32'hABCD_0000);                       // LUI
        exec_i(6'h0D, 32'hF000_0000, 16'h8001, 32'hF000_8001);               // ORI
        exec_i(6'h09, 32'h0000_0010, 16'hFFFF, 32'h0000_000F);               // ADDIU

        exec_r(6'h23, 32'd3, 32'd5, 16'h0000, 32'hFFFF_FFFE);                // SUBU
        exec_r(6'h03, 32'd0, 32'h8000_0000, 16'h0100, 32'hF800_0000);        // SRA by 4
        exec_r(6'h04, 32'd4, 32'd1, 16'h0000, 32'h0000_0010);                // SLLV
        exec_r(6'h2A, 32'hFFFF_FFFF, 32'd0, 16'h0000, 32'd1);                // SLT
        exec_r(6'h2B, 32'hFFFF_FFFF, 32'd0, 16'h0000, 32'd0);                // SLTU
        exec_r(6'h27, 32'd0, 32'd0, 16'h0000, 32'hFFFF_FFFF);                // NOR

        fetch(6'h00, 6'h08, 32'h0000_0400, 32'd0, 16'h0000, 1'b0);           // JR
        chk(S_STATE, 32'd1); chk(S_PCW, 32'd1); chk(S_PCSRC, 32'd1); chk(S_REGW, 32'd0);
        step();

        fetch(6'h3F, 6'h00, 32'd1, 32'd2, 16'h1234, 1'b0);                   // unknown opcode
        chk(S_STATE, 32'd1); chk(S_PCW, 32'd1); chk(S_REGW, 32'd0); chk(S_RAMW, 32'd0);
        chk(S_RD, 32'd0); chk(S_RT, 32'd0);
        step();

        fetch(6'h00, 6'h18, 32'hFFFF_FFFF, 32'd2, 16'h0000, 1'b0);           // MULT
        chk(S_STATE, 32'd1); chk(S_PCW, 32'd1); chk(S_REGW, 32'd0);
        step();
        exp_hi = MD ? 32'hFFFF_FFFF : 32'd0; exp_lo = MD ? 32'hFFFF_FFFE : 32'd0;

        fetch(6'h00, 6'h19, 32'hFFFF_FFFF, 32'd2, 16'h0000, 1'b0);           // MULTU
        chk(S_PCW, 32'd1); chk(S_REGW, 32'd0);
        step();
        exp_hi = MD ? 32'd1 : 32'd0;

        fetch(6'h00, 6'h10, 32'd0, 32'd0, 16'h0000, 1'b0);                   // MFHI
        chk(S_RD, MD ? 32'd1 : 32'd0); chk(S_REGW, {31'd0, MD}); chk(S_PCW, 32'd1);
        step();
        fetch(6'h00, 6'h12, 32'd0, 32'd0, 16'h0000, 1'b0);                   // MFLO
        chk(S_RD, MD ? 32'hFFFF_FFFE : 32'd0); chk(S_REGW, {31'd0, MD});
        step();

        div_seq(6'h1B, 32'd100, 32'd7);                                      // DIVU
        exp_lo = MD ? 32'd14 : 32'd0; exp_hi = MD ? 32'd2 : 32'd0;
        div_seq(6'h1A, 32'hFFFF_FFF9, 32'd2);                                // DIV -7/2
        exp_lo = MD ? 32'hFFFF_FFFD : 32'd0; exp_hi = MD ? 32'hFFFF_FFFF : 32'd0;
        div_seq(6'h1B, 32'h0000_1234, 32'd0);                                // DIVU by zero
        exp_lo = MD ? 32'hFFFF_FFFF : 32'd0; exp_hi = MD ? 32'h0000_1234 : 32'd0;

        fetch(6'h00, 6'h13, 32'h0000_0055, 32'd0, 16'h0000, 1'b0);           // MTLO
        chk(S_PCW, 32'd1); chk(S_REGW, 32'd0);
        step();
        exp_lo = MD ? 32'h0000_0055 : 32'd0;
        fetch(6'h00, 6'h11, 32'h0000_000A, 32'd0, 16'h0000, 1'b0);           // MTHI
        step();
        exp_hi = MD ? 32'h0000_000A : 32'd0;

        fetch(6'h00, 6'h1B, 32'd100, 32'd7, 16'h0000, 1'b0);                 // DIVU aborted by reset
        chk(S_STATE, 32'd1); chk(S_STALL, {31'd0, MD});
        step();
        chk(S_STATE, MD ? 32'd1 : 32'd0);
        step();
        reset_i = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        chk(S_STATE, 32'd0); chk(S_STALL, 32'd0); chk(S_HI, 32'd0); chk(S_LO, 32'd0);
        chk(S_PCW, 32'd0); chk(S_IRW, 32'd0);
        step();
        reset_i = 1'b1;

        fetch(6'h3F, 6'h00, 32'd0, 32'd0, 16'h0000, 1'b1);                   // halt
        for (int k = 0; k < 10; k++) begin
            chk(S_STATE, 32'd3); chk(S_ACT, 32'd0); chk(S_PCW, 32'd0); chk(S_IRW, 32'd0);
            chk(S_RDS, 32'd0); chk(S_REGW, 32'd0); chk(S_RAMW, 32'd0); chk(S_PCSRC, 32'd0);
            step();
        end
        reset_i = 1'b0;
        chk(S_STATE, 32'd0); chk(S_ACT, 32'd1);
        step();
        reset_i = 1'b1;
        halt_i = 1'b0;
        chk(S_STATE, 32'd0); chk(S_IRW, 32'd1);

        end_req = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_exec.md
Name: mips_ctrl_exec

Overview:
- Multicycle MIPS control and execute core: instruction-cycle FSM, control decoder and ALU with HI/LO and an iterative divider, in one block.
- Sits between the IR/regfile/PC datapath and the Avalon bus glue.
- Consumes decoded instruction fields and register operands.
- Produces the state, datapath enables/selects, ALU results and a stall.

Parameters:
- DIV_CYCLES, 32, number of divider iterations; stall length for DIV/DIVU.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- halt_i  in  1  PC==0 indication from the datapath.
- opcode_i  in  6  instruction opcode.
- funct_i  in  6  R-type function field.
- rs_i  in  32  rs register value.
- rt_i  in  32  rt register value.
- immediate_i  in  16  instruction immediate.
- state_o  out  2  FETCH=0, EXEC1=1, EXEC2=2, HALT=3.
- active_o  out  1  high when state_o is not HALT.
- pc_wen_o, ir_wen_o, ram_wen_o, ram_rds_o, reg_wen_o  out  1 each  write/read strobes.
- src_b_sel_o  out  1  1 = ALU operand B is the immediate; 0 = rt_i.
- ram_a_sel_o  out  1  1 = bus address is the ALU result; 0 = PC.
- reg_wd_sel_o  out  1  1 = register write data is the ALU result; 0 = bus readdata.
- reg_a3_sel_o  out  1  1 = register write address is rd; 0 = rt.
- pc_src_o  out  1  1 = PC loads rs_i (JR).
- rd_o  out  32  R-type result.
- rt_o  out  32  I-type result or LW/SW effective address.
- mfhi_o, mflo_o  out  32 each  HI and LO register contents.
- stall_o  out  1  ALU busy; holds the FSM in EXEC1.

Behaviour:
- Reset (reset_i=0, asynchronous): state FETCH; HI=LO=0; divider idle.
  - While reset_i=0, every strobe and pc_src_o is forced to 0.
- FSM transitions:
  - FETCH: if halt_i then HALT, else EXEC1.
  - EXEC1: stay while stall_o=1; otherwise go to EXEC2 for LW, else FETCH.
  - EXEC2: always FETCH.
  - HALT: absorbing until reset.
- Control outputs are purely combinational from state and opcode/funct.
  - FETCH: ir_wen=1, ram_rds=1, ram_a_sel=0.
  - EXEC1, ALU R-type ops (ADDU SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV MFHI MFLO):
    - reg_wen=1, reg_a3_sel=1, reg_wd_sel=1, src_b_sel=0, pc_wen=1.
  - EXEC1, ALU I-type ops (ADDIU ANDI ORI XORI SLTI SLTIU LUI):
    - reg_wen=1, reg_a3_sel=0, reg_wd_sel=1, src_b_sel=1, pc_wen=1.
  - EXEC1, LW: ram_rds=1, ram_a_sel=1, src_b_sel=1.
  - EXEC2, LW: reg_wen=1, reg_a3_sel=0, reg_wd_sel=0, pc_wen=1.
  - EXEC1, SW: ram_wen=1, ram_a_sel=1, src_b_sel=1, pc_wen=1.
  - EXEC1, JR: pc_wen=1, pc_src=1.
  - EXEC1, MULT MULTU MTHI MTLO: pc_wen=1 only.
  - EXEC1, DIV DIVU: pc_wen=1 only, and only in the cycle where stall_o=0.
  - Unknown opcode: NOP (pc_wen=1 in EXEC1, no other writes).
  - HALT: all strobes 0.
- ALU results (combinational):
  - All arithmetic is 32-bit and wraps; no overflow traps.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; sign-extended immediate for SLTIU.
  - ADDIU, SLTI, LW and SW use the sign-extended immediate.
  - ANDI, ORI and XORI use the zero-extended immediate.
  - LUI result = {imm,16'h0}.
  - Shift amount is immediate_i[10:6] for fixed shifts and rs_i[4:0] for variable shifts.
  - rd_o and rt_o read 0 when not applicable.
- HI/LO updates (registered, on the EXEC1 cycle's clock edge):
  - MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product.
  - MTHI/MTLO: HI or LO = rs_i.
- Divider (DIV/DIVU):
  - Starts on the first EXEC1 cycle.
  - stall_o=1 for exactly DIV_CYCLES cycles; the next EXEC1 cycle has stall_o=0, and on that cycle's edge LO=quotient, HI=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO=32'hFFFFFFFF, HI=dividend.
  - Reset mid-division aborts it: stall_o=0 and HI/LO=0.

Optional Feature:
- MULDIV_EN defined: MULT MULTU DIV DIVU MFHI MFLO MTHI MTLO are implemented as above.
- MULDIV_EN undefined:
  - Those functs decode as NOP.
  - stall_o tied to 0.
  - mfhi_o=mflo_o=0.
  - No HI/LO or divider logic is synthesised.

Decomposition:
- Shared package mips_pkg holds:
  - state_t enum (FETCH, EXEC1, EXEC2, HALT);
  - opcode_t and func_t enums with MIPS encodings;
  - size_t (32-bit) and regaddr_t (5-bit) typedefs.
- One natural sub-module, mips_divider: iterative restoring divider with start/busy/quotient/remainder.

Test Plan:
- Reset release, halt_i=0, ADDU, rs=5, rt=7: state sequence 0→1→0; rd_o=12, reg_wen=1 in EXEC1.
- LW, rs=0x1000, imm=0xFFFC: rt_o=0x0FFC, ram_rds=1, ram_a_sel=1 in EXEC1; EXEC2 asserts reg_wen=1, reg_wd_sel=0.
- DIVU 100/7: stall_o high 32 cycles, then LO=14, HI=2; DIV -7/2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULT 0xFFFFFFFF×2: HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands: HI=1, LO=0xFFFFFFFE.
- halt_i=1 in FETCH: next state HALT, active_o=0, all strobes 0 for 10 cycles; reset_i low returns state to FETCH asynchronously.
- SLTI rs=0xFFFFFFFF, imm=1 → rt_o=1; SLTIU with the same operands → rt_o=0; LUI imm=0xABCD → rt_o=0xABCD0000.
